// File: rtl/io_bus_arb.sv
// io_bus_arb -- two-master arbiter (m0 = CPU, m1 = DMA) onto a single IO bus.
//
// Purpose:
//   Grants at most one master per cycle. The grant is combinational from the
//   current requests and registered arbiter state. The granted command is driven
//   straight onto the io_* strobes in the same cycle. Read data returns one
//   cycle later and is steered to the master that issued the read.
//   A master may hold the bus across consecutive grants with mN_lock. A lock is
//   broken when the owner drops lock or request, or on the 16th grant of the
//   burst (forced release). After a forced release, a waiting master wins the
//   next cycle.
//
// Configuration macro:
//   IO_ARB_RR_EN  defined   -> round-robin arbitration in IDLE
//                 undefined -> fixed priority, m0 over m1
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_req/we/adr/wdata/lock   master N command (N = 0, 1)
//   mN_gnt                     command accepted this cycle
//   mN_rdata/mN_rvalid         read return to master N (rdata 0 when not valid)
//   io_we/io_wadr/io_wdata     bus write strobe, address, data
//   io_radr_en/io_radr         bus read strobe, address
//   io_rdata                   bus read data, one cycle after io_radr_en
//   arb_locked                 a lock is active
module io_bus_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [13:0] m0_adr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [13:0] m1_adr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        io_we,
  output logic [13:0] io_wadr,
  output logic [31:0] io_wdata,
  output logic [13:0] io_radr,
  output logic        io_radr_en,
  input  logic [31:0] io_rdata,
  output logic        arb_locked
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t      state, state_nxt;
  logic [4:0]  burst_cnt, burst_cnt_nxt;
  logic        fr_vld, fr_vld_nxt;   // previous cycle was a forced release
  logic        fr_own, fr_own_nxt;   // master that was forced off
`ifdef IO_ARB_RR_EN
  logic        rr_ptr, rr_ptr_nxt;   // master favoured on a tie (0 = m0)
`endif
  logic        rd_vld_p1;            // read in flight, data on io_rdata now
  logic        rd_own_p1;            // master that issued it

  logic        gnt0, gnt1, any_gnt;
  logic        g_we, g_lock, owner_req;
  logic [13:0] g_adr;
  logic [31:0] g_wdata;

  // Stage p0: combinational arbitration and bus drive
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      LOCK0:   gnt0 = m0_req;
      LOCK1:   gnt1 = m1_req;
      default: begin
        if (m0_req && m1_req) begin
          if (fr_vld) begin
            // the master just forced off yields to the waiting one
            gnt0 = fr_own;
            gnt1 = ~fr_own;
          end else begin
`ifdef IO_ARB_RR_EN
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
`else
            gnt0 = 1'b1;
`endif
          end
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
    endcase
    // no grant may leak out while reset is held
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign g_we    = gnt1 ? m1_we    : m0_we;
  assign g_lock  = gnt1 ? m1_lock  : m0_lock;
  assign g_adr   = gnt1 ? m1_adr   : m0_adr;
  assign g_wdata = gnt1 ? m1_wdata : m0_wdata;

  assign m0_gnt     = gnt0;
  assign m1_gnt     = gnt1;
  assign io_we      = any_gnt & g_we;
  assign io_radr_en = any_gnt & ~g_we;
  assign io_wadr    = io_we      ? g_adr   : 14'd0;
  assign io_wdata   = io_we      ? g_wdata : 32'd0;
  assign io_radr    = io_radr_en ? g_adr   : 14'd0;
  assign arb_locked = (state != IDLE);

  assign owner_req  = (state == LOCK1) ? m1_req : m0_req;

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    fr_vld_nxt    = 1'b0;
    fr_own_nxt    = fr_own;
`ifdef IO_ARB_RR_EN
    rr_ptr_nxt    = rr_ptr;
    if (gnt0)      rr_ptr_nxt = 1'b1;
    else if (gnt1) rr_ptr_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (any_gnt && g_lock) begin
          state_nxt     = gnt1 ? LOCK1 : LOCK0;
          burst_cnt_nxt = 5'd1;
        end
      end
      default: begin
        if (!owner_req) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = 5'd0;
        end else if (burst_cnt == 5'd15) begin
          // this grant is the 16th of the burst
          state_nxt     = IDLE;
          burst_cnt_nxt = 5'd0;
          fr_vld_nxt    = 1'b1;
          fr_own_nxt    = (state == LOCK1);
        end else if (!g_lock) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = 5'd0;
        end else begin
          burst_cnt_nxt = burst_cnt + 5'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= 5'd0;
      fr_vld    <= 1'b0;
      fr_own    <= 1'b0;
`ifdef IO_ARB_RR_EN
      rr_ptr    <= 1'b0;
`endif
      rd_vld_p1 <= 1'b0;
      rd_own_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      fr_vld    <= fr_vld_nxt;
      fr_own    <= fr_own_nxt;
`ifdef IO_ARB_RR_EN
      rr_ptr    <= rr_ptr_nxt;
`endif
      rd_vld_p1 <= io_radr_en;
      rd_own_p1 <= gnt1;
    end
  end

  // Stage p1: read return steered to its issuer
  assign m0_rvalid = rd_vld_p1 & ~rd_own_p1;
  assign m1_rvalid = rd_vld_p1 &  rd_own_p1;
  assign m0_rdata  = m0_rvalid ? io_rdata : 32'd0;
  assign m1_rdata  = m1_rvalid ? io_rdata : 32'd0;

endmodule

// File: tb/tb_io_bus_arb.sv
// tb_io_bus_arb -- directed bench for io_bus_arb.
// Inputs change on the falling edge; outputs are checked 1 ns later,
// well before the next rising edge.
module tb_io_bus_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [13:0] m0_adr, m1_adr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        io_we, io_radr_en, arb_locked;
  logic [13:0] io_wadr, io_radr;
  logic [31:0] io_wdata, io_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  io_bus_arb dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .io_we(io_we), .io_wadr(io_wadr), .io_wdata(io_wdata), .io_radr(io_radr),
    .io_radr_en(io_radr_en), .io_rdata(io_rdata), .arb_locked(arb_locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // apply one cycle of master commands and bus read data
  task automatic drive(input logic r0, input logic w0, input logic l0,
                       input logic [13:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [13:0] a1, input logic [31:0] d1,
                       input logic [31:0] rd);
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_adr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_adr = a1; m1_wdata = d1;
    io_rdata = rd;
    #1;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_io_we"},   {31'd0, io_we},      32'd0);
    chk({tag, "_io_ren"},  {31'd0, io_radr_en}, 32'd0);
    chk({tag, "_io_wadr"}, {18'd0, io_wadr},    32'd0);
    chk({tag, "_io_radr"}, {18'd0, io_radr},    32'd0);
    chk({tag, "_io_wd"},   io_wdata,            32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_adr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_adr = '0; m1_wdata = '0;
    io_rdata = '0;

    // reset state
    #2;
    chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
    chk("rst_gnt1", {31'd0, m1_gnt}, 32'd0);
    chk("rst_rv0", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_lock", {31'd0, arb_locked}, 32'd0);
    chk_idle_bus("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // m0 write 0x3F80 <- 5
    drive(1, 1, 0, 14'h3F80, 32'h5, 0, 0, 0, 14'h0, 32'h0, 32'h0);
    chk("w_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("w_gnt1", {31'd0, m1_gnt}, 32'd0);
    chk("w_io_we", {31'd0, io_we}, 32'd1);
    chk("w_wadr", {18'd0, io_wadr}, 32'h3F80);
    chk("w_wdata", io_wdata, 32'h5);
    chk("w_ren", {31'd0, io_radr_en}, 32'd0);
    chk("w_radr", {18'd0, io_radr}, 32'd0);

    // m0 read 0x3F85, returns 0xA
    drive(1, 0, 0, 14'h3F85, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0);
    chk("r_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("r_ren", {31'd0, io_radr_en}, 32'd1);
    chk("r_radr", {18'd0, io_radr}, 32'h3F85);
    chk("r_io_we", {31'd0, io_we}, 32'd0);
    chk("r_wadr", {18'd0, io_wadr}, 32'd0);
    drive(0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'hA);
    chk("r_rv0", {31'd0, m0_rvalid}, 32'd1);
    chk("r_rd0", m0_rdata, 32'hA);
    chk("r_rv1", {31'd0, m1_rvalid}, 32'd0);
    chk("r_rd1", m1_rdata, 32'h0);
    chk("r_nogntA", {31'd0, m0_gnt}, 32'd0);
    chk_idle_bus("nogntA");

    // m1 back-to-back reads 0x10, 0x11
    drive(0, 0, 0, 14'h0, 32'h0, 1, 0, 0, 14'h10, 32'h0, 32'h0);
    chk("bb_gnt1a", {31'd0, m1_gnt}, 32'd1);
    chk("bb_rv0a", {31'd0, m0_rvalid}, 32'd0);
    drive(0, 0, 0, 14'h0, 32'h0, 1, 0, 0, 14'h11, 32'h0, 32'h111);
    chk("bb_gnt1b", {31'd0, m1_gnt}, 32'd1);
    chk("bb_radrb", {18'd0, io_radr}, 32'h11);
    chk("bb_rv1b", {31'd0, m1_rvalid}, 32'd1);
    chk("bb_rd1b", m1_rdata, 32'h111);
    drive(0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h222);
    chk("bb_rv1c", {31'd0, m1_rvalid}, 32'd1);
    chk("bb_rd1c", m1_rdata, 32'h222);
    chk("bb_rv0c", {31'd0, m0_rvalid}, 32'd0);
    chk("bb_rd0c", m0_rdata, 32'h0);

    // both masters request continuously (last grant went to m1)
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 14'h20, 32'h0, 1, 0, 0, 14'h30, 32'h0, 32'h0);
`ifdef IO_ARB_RR_EN
      chk($sformatf("arb_gnt0_%0d", i), {31'd0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("arb_gnt1_%0d", i), {31'd0, m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
`else
      chk($sformatf("arb_gnt0_%0d", i), {31'd0, m0_gnt}, 32'd1);
      chk($sformatf("arb_gnt1_%0d", i), {31'd0, m1_gnt}, 32'd0);
`endif
    end
    drive(0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0);

    // m1 locked burst with m0 waiting: 16 m1 grants then forced release
    drive(0, 0, 0, 14'h0, 32'h0, 1, 0, 1, 14'h100, 32'h0, 32'h0);
    chk("lk_gnt1_1", {31'd0, m1_gnt}, 32'd1);
    chk("lk_locked_1", {31'd0, arb_locked}, 32'd0);
    for (int i = 2; i <= 16; i++) begin
      drive(1, 0, 0, 14'h40, 32'h0, 1, 0, 1, 14'h100 + 14'(i), 32'h0, 32'h0);
      chk($sformatf("lk_gnt1_%0d", i), {31'd0, m1_gnt}, 32'd1);
      chk($sformatf("lk_gnt0_%0d", i), {31'd0, m0_gnt}, 32'd0);
      chk($sformatf("lk_locked_%0d", i), {31'd0, arb_locked}, 32'd1);
    end
    drive(1, 0, 0, 14'h40, 32'h0, 1, 0, 1, 14'h111, 32'h0, 32'h0);
    chk("fr_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("fr_gnt1", {31'd0, m1_gnt}, 32'd0);
    chk("fr_locked", {31'd0, arb_locked}, 32'd0);
    chk("fr_radr", {18'd0, io_radr}, 32'h40);
    // m1 alone takes the lock again, then drops its request
    drive(0, 0, 0, 14'h0, 32'h0, 1, 0, 1, 14'h112, 32'h0, 32'h0);
    chk("rl_gnt1", {31'd0, m1_gnt}, 32'd1);
    drive(0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0);
    chk("rl_locked", {31'd0, arb_locked}, 32'd1);
    drive(0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0);
    chk("rl_unlocked", {31'd0, arb_locked}, 32'd0);

    // m0 lock released by lock=0 while m1 waits
    drive(1, 1, 1, 14'h50, 32'h77, 1, 0, 0, 14'h60, 32'h0, 32'h0);
    chk("l0_gnt0a", {31'd0, m0_gnt}, 32'd1);
    drive(1, 1, 0, 14'h51, 32'h78, 1, 0, 0, 14'h60, 32'h0, 32'h0);
    chk("l0_gnt0b", {31'd0, m0_gnt}, 32'd1);
    chk("l0_gnt1b", {31'd0, m1_gnt}, 32'd0);
    chk("l0_lockb", {31'd0, arb_locked}, 32'd1);
    chk("l0_wdatab", io_wdata, 32'h78);
    drive(0, 0, 0, 14'h0, 32'h0, 1, 0, 0, 14'h60, 32'h0, 32'h0);
    chk("l0_gnt1c", {31'd0, m1_gnt}, 32'd1);
    chk("l0_lockc", {31'd0, arb_locked}, 32'd0);

    // read in flight dropped by reset
    drive(1, 0, 0, 14'h55, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0);
    chk("rr_gnt0", {31'd0, m0_gnt}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    io_rdata = 32'hDEAD;
    #1;
    chk("rr_rv0", {31'd0, m0_rvalid}, 32'd0);
    chk("rr_rd0", m0_rdata, 32'h0);
    chk("rr_gnt0_rst", {31'd0, m0_gnt}, 32'd0);
    chk("rr_lock", {31'd0, arb_locked}, 32'd0);
    chk_idle_bus("rr");
    @(negedge clk);
    rst_n = 1'b1;
    m0_req = 1'b0;
    #1;
    chk("rr_rv0_post", {31'd0, m0_rvalid}, 32'd0);
    chk("rr_rv1_post", {31'd0, m1_rvalid}, 32'd0);
    @(negedge clk);
    #1;
    chk("rr_rv0_post2", {31'd0, m0_rvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
